// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
// Sends one command byte to the device. The sequence is: inhibit the clock,
// request to send, shift out the bits on device clock falling edges, check
// the device ACK, then wait for the bus to go idle. Both lines are
// open-collector, so an *_oe output of 1 pulls the line low.
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   tx_data, tx_valid   command byte and request (accepted when tx_ready)
//   tx_ready            high only while idle
//   tx_done, tx_error   one-cycle completion / failure (NACK or timeout) pulses
//   busy                high whenever a transfer is in progress
//   ps2_clk_in/data_in  raw line levels
//   ps2_clk_oe/data_oe  line pull-down enables
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 200,
  parameter int unsigned TIMEOUT_CYCLES = 30000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_data_s1, r_data_s2;
  logic [7:0]       r_byte;
  logic             r_parity;
  logic             r_bit_oe;
  logic [3:0]       r_edge_cnt;
  logic [INH_W-1:0] r_inh_cnt;
  logic [14:0]      r_to_cnt;
  logic             w_fall;
  logic             w_timeout;
  logic             w_accept;

  // Two-flop synchronizers; r_clk_prev holds the previous synced clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_data_s1  <= 1'b1;
      r_data_s2  <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk_in;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_data_s1  <= ps2_data_in;
      r_data_s2  <= r_data_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // The timeout covers everything after the request is released.
  assign w_timeout = ((r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE)) &&
                     (r_to_cnt == 15'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_byte     <= '0;
      r_parity   <= 1'b0;
      r_bit_oe   <= 1'b0;
      r_edge_cnt <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_byte     <= tx_data;
            r_parity   <= ~^tx_data;
            r_edge_cnt <= '0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
          end
        end
        S_INHIBIT: r_inh_cnt <= r_inh_cnt + 1'b1;
        S_REQ: begin
          r_bit_oe   <= 1'b1;  // start bit continues into SEND
          r_edge_cnt <= '0;
          r_to_cnt   <= '0;
        end
        S_SEND: begin
          r_to_cnt <= r_to_cnt + 15'd1;
          if (w_fall) begin
            r_edge_cnt <= r_edge_cnt + 4'd1;
            // Edge n puts bit n-1 on the line; edge 9 parity, edge 10 stop.
            if (r_edge_cnt < 4'd8)       r_bit_oe <= ~r_byte[r_edge_cnt[2:0]];
            else if (r_edge_cnt == 4'd8) r_bit_oe <= ~r_parity;
            else                         r_bit_oe <= 1'b0;
          end
        end
        S_ACK, S_WAIT_IDLE: r_to_cnt <= r_to_cnt + 15'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    tx_ready     = 1'b0;
    busy         = 1'b1;
    tx_done      = 1'b0;
    tx_error     = 1'b0;
    ps2_clk_oe   = 1'b0;
    ps2_data_oe  = 1'b0;
    case (r_state)
      S_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) w_state_next = S_REQ;
      end
      S_REQ: begin
        ps2_clk_oe   = 1'b1;
        ps2_data_oe  = 1'b1;
        w_state_next = S_SEND;
      end
      S_SEND: begin
        // Timeout takes priority over a coincident edge and frees the line at once.
        if (w_timeout) begin
          tx_error     = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          ps2_data_oe = r_bit_oe;
          if (w_fall && (r_edge_cnt == 4'd9)) w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        if (w_timeout) begin
          tx_error     = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_fall) begin
          if (r_data_s2) begin
            tx_error     = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_timeout) begin
          tx_error     = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_clk_s2 && r_data_s2) begin
          tx_done      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_error, busy, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  // Open-collector wired-AND of host and device.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt_done = 0;
  int   cnt_err = 0;
  bit   flag_both = 0;
  bit   flag_long = 0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  always #5 clk = ~clk;

  ps2_host_tx dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_error(tx_error), .busy(busy),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always @(negedge clk) begin
    if (tx_done) cnt_done++;
    if (tx_error) cnt_err++;
    if (tx_done && tx_error) flag_both = 1;
    if ((tx_done && prev_done) || (tx_error && prev_err)) flag_long = 1;
    prev_done = tx_done;
    prev_err  = tx_error;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Device: waits for the start bit with the clock released, then generates
  // n_edges clock pulses, sampling the data line at each rising edge.
  task automatic dev_run(input bit ack_low, input int n_edges,
                         output logic [10:0] smp, output bit started);
    int n = 0;
    smp = '0;
    while (!(busy && !ps2_clk_oe && ps2_data_oe) && n < 1000) begin
      tick(1);
      n++;
    end
    started = (n < 1000);
    if (started) begin
      tick(HALF);
      for (int k = 1; k <= n_edges; k++) begin
        if (k == 11 && ack_low) begin
          dev_data = 1'b0;
          tick(2);
        end
        dev_clk = 1'b0;
        tick(HALF);
        dev_clk = 1'b1;
        smp[k-1] = ps2_data_in;
        tick(HALF);
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(3);
    n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    n_cmp++; if (ps2_data_oe !== 1'b0) begin n_bad++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if ({tx_done, tx_error} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b want 00", {tx_done, tx_error}); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_send(input logic [7:0] b, input logic [7:0] exp_bits, input logic exp_par);
    int d0 = cnt_done;
    int e0 = cnt_err;
    int n = 0;
    logic [10:0] smp;
    bit st;
    tx_data = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    n_cmp++; if ({busy, tx_ready} !== 2'b10) begin n_bad++; $display("FAIL send_%h_busy_ready: got %b want 10", b, {busy, tx_ready}); end
    dev_run(1'b1, 11, smp, st);
    n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL send_%h_start: got %b want 1", b, st); end
    n_cmp++; if (smp[7:0] !== exp_bits) begin n_bad++; $display("FAIL send_%h_bits: got %h want %h", b, smp[7:0], exp_bits); end
    n_cmp++; if (smp[8] !== exp_par) begin n_bad++; $display("FAIL send_%h_parity: got %b want %b", b, smp[8], exp_par); end
    n_cmp++; if (smp[9] !== 1'b1) begin n_bad++; $display("FAIL send_%h_stop: got %b want 1", b, smp[9]); end
    while (cnt_done == d0 && cnt_err == e0 && n < 500) begin tick(1); n++; end
    n_cmp++; if (cnt_done !== d0 + 1) begin n_bad++; $display("FAIL send_%h_done_count: got %0d want %0d", b, cnt_done, d0 + 1); end
    n_cmp++; if (cnt_err !== e0) begin n_bad++; $display("FAIL send_%h_err_count: got %0d want %0d", b, cnt_err, e0); end
    tick(1);
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL send_%h_ready_after: got %b want 1", b, tx_ready); end
    n_cmp++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_bad++; $display("FAIL send_%h_oe_after: got %b want 00", b, {ps2_clk_oe, ps2_data_oe}); end
  endtask

  task automatic test_nack;
    int d0 = cnt_done;
    int e0 = cnt_err;
    int n = 0;
    logic [10:0] smp;
    bit st;
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    dev_run(1'b0, 11, smp, st);
    n_cmp++; if (smp[7:0] !== 8'hF4) begin n_bad++; $display("FAIL nack_bits: got %h want f4", smp[7:0]); end
    while (cnt_done == d0 && cnt_err == e0 && n < 500) begin tick(1); n++; end
    n_cmp++; if (cnt_err !== e0 + 1) begin n_bad++; $display("FAIL nack_err_count: got %0d want %0d", cnt_err, e0 + 1); end
    n_cmp++; if (cnt_done !== d0) begin n_bad++; $display("FAIL nack_done_count: got %0d want %0d", cnt_done, d0); end
    n_cmp++; if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin n_bad++; $display("FAIL nack_idle: got %b want 001", {ps2_clk_oe, ps2_data_oe, tx_ready}); end
  endtask

  task automatic test_timeout;
    int d0 = cnt_done;
    int e0 = cnt_err;
    int n_inh = 0;
    int n_req = 0;
    int n = 0;
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    while (ps2_clk_oe && !ps2_data_oe && n_inh < 1000) begin tick(1); n_inh++; end
    n_cmp++; if (n_inh !== 200) begin n_bad++; $display("FAIL timeout_inhibit_len: got %0d want 200", n_inh); end
    while (ps2_clk_oe && ps2_data_oe && n_req < 10) begin tick(1); n_req++; end
    n_cmp++; if (n_req !== 1) begin n_bad++; $display("FAIL timeout_req_len: got %0d want 1", n_req); end
    while (!tx_error && n < 40000) begin tick(1); n++; end
    // n + 1 counts cycles from the REQ cycle to the error cycle.
    n_cmp++; if (n + 1 !== 30000) begin n_bad++; $display("FAIL timeout_len: got %0d want 30000", n + 1); end
    n_cmp++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_bad++; $display("FAIL timeout_release: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    tick(1);
    n_cmp++; if (cnt_err !== e0 + 1) begin n_bad++; $display("FAIL timeout_err_count: got %0d want %0d", cnt_err, e0 + 1); end
    n_cmp++; if (cnt_done !== d0) begin n_bad++; $display("FAIL timeout_done_count: got %0d want %0d", cnt_done, d0); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL timeout_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_reset_mid;
    int d0 = cnt_done;
    int e0 = cnt_err;
    logic [10:0] smp;
    bit st;
    // 0xED has bit 4 = 0, so the data line is being pulled low at edge 5.
    tx_data = 8'hED;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    dev_run(1'b1, 5, smp, st);
    n_cmp++; if (smp[4:0] !== 5'b01101) begin n_bad++; $display("FAIL rmid_bits: got %b want 01101", smp[4:0]); end
    n_cmp++; if (ps2_data_oe !== 1'b1) begin n_bad++; $display("FAIL rmid_data_before: got %b want 1", ps2_data_oe); end
    reset = 1'b1;
    tick(1);
    n_cmp++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin n_bad++; $display("FAIL rmid_release: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    n_cmp++; if ({busy, tx_ready} !== 2'b01) begin n_bad++; $display("FAIL rmid_idle: got %b want 01", {busy, tx_ready}); end
    reset = 1'b0;
    tick(2);
    n_cmp++; if ({cnt_done, cnt_err} !== {d0, e0}) begin n_bad++; $display("FAIL rmid_no_pulse: got %0d/%0d want %0d/%0d", cnt_done, cnt_err, d0, e0); end
    test_send(8'hF4, 8'b1111_0100, 1'b0);
  endtask

  task automatic test_back_to_back;
    int d0 = cnt_done;
    int e0 = cnt_err;
    int n = 0;
    logic [10:0] smp;
    bit st;
    tx_data = 8'hF4;
    tx_valid = 1'b1;
    tick(1);
    tx_data = 8'h55;
    dev_run(1'b1, 11, smp, st);
    n_cmp++; if (smp[7:0] !== 8'hF4) begin n_bad++; $display("FAIL b2b_first_bits: got %h want f4", smp[7:0]); end
    while (cnt_done == d0 && cnt_err == e0 && n < 500) begin tick(1); n++; end
    n_cmp++; if (cnt_done !== d0 + 1) begin n_bad++; $display("FAIL b2b_first_done: got %0d want %0d", cnt_done, d0 + 1); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", tx_ready); end
    tick(1);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: got %b want 1", busy); end
    tx_valid = 1'b0;
    dev_run(1'b1, 11, smp, st);
    n_cmp++; if (smp[7:0] !== 8'h55) begin n_bad++; $display("FAIL b2b_second_bits: got %h want 55", smp[7:0]); end
    n_cmp++; if (smp[8] !== 1'b1) begin n_bad++; $display("FAIL b2b_second_parity: got %b want 1", smp[8]); end
    n = 0;
    while (cnt_done == d0 + 1 && n < 500) begin tick(1); n++; end
    n_cmp++; if ({cnt_done, cnt_err} !== {d0 + 2, e0}) begin n_bad++; $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", cnt_done, cnt_err, d0 + 2, e0); end
  endtask

  task automatic test_pulses;
    n_cmp++; if (flag_both !== 1'b0) begin n_bad++; $display("FAIL pulse_overlap: got %b want 0", flag_both); end
    n_cmp++; if (flag_long !== 1'b0) begin n_bad++; $display("FAIL pulse_width: got %b want 0", flag_long); end
  endtask

  initial begin
    test_reset();
    test_send(8'hF4, 8'b1111_0100, 1'b0);
    test_send(8'hED, 8'b1110_1101, 1'b1);
    test_send(8'hFF, 8'b1111_1111, 1'b1);
    test_send(8'h00, 8'b0000_0000, 1'b1);
    test_nack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_pulses();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 200, clk cycles ps2_clk held low before request (100 us at 2 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 30000, max clk cycles from request release to ACK before abort (15 ms at 2 MHz).
REQ-003 SHALL have port clk  input  1  system clock (2 MHz nominal).
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port tx_data  input  8  command byte to send to device.
REQ-006 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-007 SHALL have port tx_ready  output  1  high only in IDLE; transfer accepted when tx_valid && tx_ready.
REQ-008 SHALL have port tx_done  output  1  one-cycle pulse, byte sent and ACKed.
REQ-009 SHALL have port tx_error  output  1  one-cycle pulse, NACK or timeout.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE (lets the receiver ignore host traffic).
REQ-011 SHALL have port ps2_clk_in  input  1  raw PS/2 clock line level.
REQ-012 SHALL have port ps2_data_in  input  1  raw PS/2 data line level.
REQ-013 SHALL have port ps2_clk_oe  output  1  1 = drive clock line low, 0 = release (open collector).
REQ-014 SHALL have port ps2_data_oe  output  1  1 = drive data line low, 0 = release (open collector).

Function
REQ-015 SHALL synchronize ps2_clk_in and ps2_data_in through two flops each; falling edge = prior synced clk 1, current synced clk 0.
REQ-016 SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe low, tx_ready=1; on tx_valid latch tx_data, compute odd parity (~^tx_data), clear counters, go INHIBIT next cycle; tx_valid while not IDLE ignored.
REQ-018 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-019 REQ: ps2_clk_oe=1, ps2_data_oe=1 (start bit) for exactly one cycle, then SEND with ps2_clk_oe=0, ps2_data_oe=1.
REQ-020 SEND: on falling edges 1..8 drive data bits 0..7 LSB first, edge 9 parity, edge 10 stop (ps2_data_oe=0); ps2_data_oe = inverse of bit value; line held between edges; after edge 10 go ACK.
REQ-021 ACK: on next falling edge sample synced data; 0 -> WAIT_IDLE; 1 -> tx_error pulse, IDLE.
REQ-022 WAIT_IDLE: wait until synced clk and data both 1, then tx_done pulse, IDLE.
REQ-023 Timeout counter SHALL start at REQ exit, run through SEND/ACK/WAIT_IDLE; on reaching TIMEOUT_CYCLES release both lines, pulse tx_error, go IDLE same cycle; timeout beats a coincident falling edge.
REQ-024 tx_done and tx_error SHALL never assert in the same cycle; each exactly one cycle.
REQ-025 Edge counter 4 bits, saturating never required (max 10); timeout counter 15 bits.

Reset
REQ-026 Reset SHALL force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_error=0, counters 0, sync flops 1.
REQ-027 Reset mid-transfer SHALL release both lines on the cycle after reset sampled and discard the latched byte without tx_done/tx_error.

Verification
REQ-028 Send 0xF4, device model clocks 11 edges, ACK low -> data bits 0,0,1,0,1,1,1,1, parity 0, stop released, tx_done one cycle, tx_ready back to 1.
REQ-029 Send 0xED -> parity 1; send 0xFF -> parity 1; send 0x00 -> parity 1; bits checked at device rising edges.
REQ-030 Send 0xF4, device leaves data high at edge 11 -> tx_error one cycle, no tx_done, both oe 0.
REQ-031 Send 0xF4, device never clocks -> clk_oe low for 200 cycles, REQ 1 cycle, tx_error after 30000 more cycles, lines released.
REQ-032 Assert reset after edge 5 -> oe lines 0 next cycle, IDLE, no pulses; new tx_valid then completes normally.
REQ-033 Hold tx_valid high with changing tx_data during transfer -> only first byte sent; second accepted only after tx_done.
